// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch stage: FSM state encodings,
// instruction size and the default reset PC.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_TRAP = 2'b10
  } state_e;

  localparam int unsigned INST_BYTES = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC computation: sequential, branch, jump and
// jump-register targets plus the fixed priority mux jr > jump > branch > pc+4.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] addr26_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;

  assign pc_plus4_o = pc_i + 32'(INST_BYTES);
  // Word offset, sign-extended and scaled to bytes; addition wraps mod 2^32.
  assign branch_tgt = pc_plus4_o + {{14{imm16_i[15]}}, imm16_i, 2'b00};
  // Jump stays within the 256 MB region of the delay-slot address.
  assign jump_tgt   = {pc_plus4_o[31:28], addr26_i, 2'b00};

  // Priority select of the next fetch address.
  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jr_i)                next_pc_o = jr_target_i;
    else if (jump_i)         next_pc_o = jump_tgt;
    else if (branch_taken_i) next_pc_o = branch_tgt;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, run/halt/trap FSM and retired-instruction counter.
// Optional build macro: DELAY_SLOT_EN (one architectural delay slot after
// every taken redirect). Without it redirects land on the next edge.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jr,
  input  logic [15:0]      imm16,
  input  logic [25:0]      addr26,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [1:0]       state,
  output logic             addr_err,
  output logic [CNT_W-1:0] inst_count
);

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        next_pc;
  logic               jr_misaligned;

`ifdef DELAY_SLOT_EN
  logic               pend_q, pend_d;
  logic [31:0]        pend_tgt_q, pend_tgt_d;
`endif

  next_pc_calc u_next_pc_calc (
    .pc_i           (pc_q),
    .branch_taken_i (branch_taken),
    .jump_i         (jump),
    .jr_i           (jr),
    .imm16_i        (imm16),
    .addr26_i       (addr26),
    .jr_target_i    (jr_target),
    .pc_plus4_o     (pc_plus4),
    .next_pc_o      (next_pc)
  );

  assign jr_misaligned = jr && (jr_target[1:0] != 2'b00);

  // Next-state logic: everything holds unless RUN advances, halts or traps.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef DELAY_SLOT_EN
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
`endif
    if (state_q == ST_RUN) begin
      if (halt) begin
        // The halt instruction itself retires.
        state_d = ST_HALT;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef DELAY_SLOT_EN
        pend_d  = 1'b0;
`endif
      end else if (!stall) begin
`ifdef DELAY_SLOT_EN
        if (pend_q) begin
          // Delay slot done: redirect inputs are ignored, land on the target.
          pc_d   = pend_tgt_q;
          pend_d = 1'b0;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (jr_misaligned) begin
          state_d = ST_TRAP;
          err_d   = 1'b1;
          pend_d  = 1'b0;
        end else begin
          if (jr || jump || branch_taken) begin
            pend_d     = 1'b1;
            pend_tgt_d = next_pc;
          end
          pc_d  = pc_plus4;
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        if (jr_misaligned) begin
          state_d = ST_TRAP;
          err_d   = 1'b1;
        end else begin
          pc_d  = next_pc;
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
    end
  end

  // State registers with asynchronous reset; reset also drops any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      err_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef DELAY_SLOT_EN
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef DELAY_SLOT_EN
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
`endif
    end
  end

  assign pc         = pc_q;
  assign state      = state_q;
  assign addr_err   = err_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
// Honours DELAY_SLOT_EN when the same macro is defined for the bench.
module tb_pc_fetch_unit;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             stall, halt, branch_taken, jump, jr;
  logic [15:0]      imm16;
  logic [25:0]      addr26;
  logic [31:0]      jr_target;
  logic [31:0]      pc, pc_plus4;
  logic [1:0]       state;
  logic             addr_err;
  logic [CNT_W-1:0] inst_count;

  int tests = 0;
  int fails = 0;

  // Behavioural model: architectural state only.
  logic [31:0]      m_pc;
  logic [1:0]       m_state;   // 0 run, 1 halt, 2 trap
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;
  logic             m_pend;
  logic [31:0]      m_tgt;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .halt         (halt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr           (jr),
    .imm16        (imm16),
    .addr26       (addr26),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .state        (state),
    .addr_err     (addr_err),
    .inst_count   (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; halt = 0; branch_taken = 0; jump = 0; jr = 0;
    imm16 = '0; addr26 = '0; jr_target = '0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_state = 2'd0; m_err = 1'b0; m_cnt = '0;
    m_pend = 1'b0; m_tgt = 32'h0;
  endtask

  // One rising edge of the architectural rules, applied to current inputs.
  task automatic model_step();
    logic [31:0] seq, tgt;
    logic        taken;
    seq   = m_pc + 32'd4;
    taken = jr | jump | branch_taken;
    if (jr)          tgt = jr_target;
    else if (jump)   tgt = {seq[31:28], addr26, 2'b00};
    else             tgt = seq + 32'($signed(imm16)) * 32'd4;
    if (m_state != 2'd0) return;
    if (halt) begin
      m_state = 2'd1; m_cnt = m_cnt + 1'b1; m_pend = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (!m_pend && jr && (jr_target % 4 != 0)) begin
      m_state = 2'd2; m_err = 1'b1; m_pend = 1'b0;
    end else begin
      m_cnt = m_cnt + 1'b1;
`ifdef DELAY_SLOT_EN
      if (m_pend) begin
        m_pc = m_tgt; m_pend = 1'b0;
      end else begin
        if (taken) begin m_pend = 1'b1; m_tgt = tgt; end
        m_pc = seq;
      end
`else
      m_pc = taken ? tgt : seq;
`endif
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_model();
    chk("pc",         {32'h0, pc},         {32'h0, m_pc});
    chk("pc_plus4",   {32'h0, pc_plus4},   {32'h0, m_pc + 32'd4});
    chk("state",      {62'h0, state},      {62'h0, m_state});
    chk("addr_err",   {63'h0, addr_err},   {63'h0, m_err});
    chk("inst_count", 64'(inst_count),     64'(m_cnt));
  endtask

  // One clock: model consumes the inputs, DUT outputs checked on the falling edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  // Under delay slots a taken redirect first lands on the slot address.
  task automatic settle(input logic [31:0] slot_pc);
`ifdef DELAY_SLOT_EN
    chk("delay_slot_pc", {32'h0, pc}, {32'h0, slot_pc});
    step();
`else
    tests++;
    if (slot_pc[1:0] != 2'b00) begin
      fails++;
      $display("FAIL settle: slot address %h not word aligned", slot_pc);
    end
`endif
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic reset_mid();
    clear_inputs();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pc",    {32'h0, pc},    64'h0);
    chk("rst_state", {62'h0, state}, 64'h0);
    chk("rst_err",   {63'h0, addr_err}, 64'h0);
    chk("rst_cnt",   64'(inst_count), 64'h0);
    #1 rst_n = 1'b1;
    $display("[TB] reset pulse: pc=%h state=%0d", pc, state);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_pc",    {32'h0, pc},        64'h0);
    chk("reset_pc4",   {32'h0, pc_plus4},  64'h4);
    chk("reset_state", {62'h0, state},     64'h0);
    chk("reset_cnt",   64'(inst_count),    64'h0);
    #4 rst_n = 1'b1;

    // Free running.
    repeat (3) step();
    chk("seq_pc",  {32'h0, pc}, 64'h0C);
    chk("seq_cnt", 64'(inst_count), 64'd3);
    $display("[TB] sequential: pc=%h cnt=%0d", pc, inst_count);
    step();
    chk("seq_pc_10", {32'h0, pc}, 64'h10);

    // Backward branch from 0x10: 0x14 - 16 = 0x04.
    branch_taken = 1; imm16 = 16'hFFFC;
    step();
    clear_inputs();
    settle(32'h14);
    chk("branch_pc", {32'h0, pc}, 64'h04);
    $display("[TB] branch: pc=%h", pc);

    repeat (7) step();
    chk("walk_pc_20", {32'h0, pc}, 64'h20);

    // Jump beats branch.
    jump = 1; branch_taken = 1; addr26 = 26'h3; imm16 = 16'h0100;
    step();
    clear_inputs();
    settle(32'h24);
    chk("jump_pc", {32'h0, pc}, 64'h0C);
    $display("[TB] jump over branch: pc=%h", pc);

    // jr beats jump and branch.
    jr = 1; jump = 1; branch_taken = 1; jr_target = 32'h40; addr26 = 26'h7; imm16 = 16'h0008;
    step();
    clear_inputs();
    settle(32'h10);
    chk("jr_pc", {32'h0, pc}, 64'h40);
    $display("[TB] jr priority: pc=%h", pc);

    // Address wrap at the top of the space.
    jr = 1; jr_target = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    settle(32'h44);
    chk("wrap_pc",  {32'h0, pc},       64'hFFFF_FFFC);
    chk("wrap_pc4", {32'h0, pc_plus4}, 64'h0);
    step();
    chk("wrap_next", {32'h0, pc}, 64'h0);
    $display("[TB] wrap: pc=%h", pc);

    // Stall holds pc and count even with a jump asserted.
    reset_mid();
    repeat (2) step();
    stall = 1; jump = 1; addr26 = 26'h10;
    repeat (2) step();
    chk("stall_pc",  {32'h0, pc}, 64'h08);
    chk("stall_cnt", 64'(inst_count), 64'd2);
    stall = 0;
    step();
    clear_inputs();
    settle(32'h0C);
    chk("unstall_pc", {32'h0, pc}, 64'h40);
    $display("[TB] stall release: pc=%h cnt=%0d", pc, inst_count);

    // Misaligned jr traps and freezes.
    jump = 1; addr26 = 26'hC;
    step();
    clear_inputs();
    settle(32'h44);
    chk("pre_trap_pc", {32'h0, pc}, 64'h30);
    jr = 1; jr_target = 32'h22;
    step();
    clear_inputs();
    chk("trap_state", {62'h0, state},    64'h2);
    chk("trap_err",   {63'h0, addr_err}, 64'h1);
    jump = 1; addr26 = 26'h1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("trap_hold_pc", {32'h0, pc}, 64'h30);
    end
    $display("[TB] trap: pc=%h state=%0d err=%0b", pc, state, addr_err);
    reset_mid();

    // Halt wins over stall; the halt instruction counts.
    repeat (6) step();
    chk("pre_halt_pc", {32'h0, pc}, 64'h18);
    halt = 1; stall = 1;
    step();
    clear_inputs();
    chk("halt_state", {62'h0, state}, 64'h1);
    chk("halt_pc",    {32'h0, pc},    64'h18);
    chk("halt_cnt",   64'(inst_count), 64'd7);
    jump = 1; jr = 1; branch_taken = 1; jr_target = 32'h100; addr26 = 26'h5;
    repeat (4) step();
    chk("halt_hold_pc",  {32'h0, pc}, 64'h18);
    chk("halt_hold_cnt", 64'(inst_count), 64'd7);
    $display("[TB] halt: pc=%h cnt=%0d", pc, inst_count);

    // Randomized traffic.
    reset_mid();
    for (int n = 0; n < 1500; n++) begin
      halt         = ($urandom_range(0, 99) < 2);
      stall        = ($urandom_range(0, 4) == 0);
      jr           = ($urandom_range(0, 5) == 0);
      jump         = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      imm16        = 16'($urandom);
      addr26       = 26'($urandom);
      jr_target    = $urandom;
      if ($urandom_range(0, 9) != 0) jr_target[1:0] = 2'b00;
      step();
      if ((m_state != 2'd0 && $urandom_range(0, 7) == 0) || (n % 250 == 249))
        reset_mid();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
